// File: rtl/u_gen_rand_hv_sparse_par_if.sv
// Beat stream of a sparse hypervector: one-hot segments plus packed indices.
// The master drives the beat and the slave drives back-pressure.
interface u_gen_rand_hv_sparse_par_if #(
  parameter int LANES          = 4,
  parameter int LENGTH_SEGMENT = 32,
  parameter int IDX_W          = 5,
  parameter int BEAT_W         = 3
);
  logic                            out_valid;
  logic                            out_ready;
  logic [LANES*LENGTH_SEGMENT-1:0] out_segments;
  logic [LANES*IDX_W-1:0]          out_indices;
  logic [BEAT_W-1:0]               out_beat_idx;
  logic                            out_last;

  modport master (
    output out_valid, out_segments, out_indices, out_beat_idx, out_last,
    input  out_ready
  );
  modport slave (
    input  out_valid, out_segments, out_indices, out_beat_idx, out_last,
    output out_ready
  );
endinterface

// File: rtl/u_gen_rand_hv_sparse_par.sv
// Sparse hypervector generator: LANES seedable Galois LFSRs each pick one set
// bit per segment, streamed LANES segments per beat over valid/ready.
module u_gen_rand_hv_sparse_par_lane #(
  parameter int               LFSR_W    = 16,
  parameter logic [LFSR_W-1:0] LFSR_TAPS = 16'hB400,
  parameter int               IDX_W     = 5,
  parameter int               LANE      = 0
) (
  input  logic              clk,
  input  logic              arst_n_in,
  input  logic              load,
  input  logic [LFSR_W-1:0] seed_in,
  input  logic              step,
  output logic [IDX_W-1:0]  idx
);
  localparam logic [LFSR_W-1:0] LANE_SALT = LFSR_W'(LANE + 1);

  logic [LFSR_W-1:0] lfsr, seeded, cur;

  // A same-cycle load feeds the beat directly, so the first beat sees the new seed
  always_comb begin
    seeded = seed_in ^ LANE_SALT;
    if (seeded == '0) seeded = LFSR_W'(1);
    cur = load ? seeded : lfsr;
  end

  assign idx = cur[IDX_W-1:0];

  always_ff @(posedge clk or negedge arst_n_in) begin
    if (!arst_n_in)  lfsr <= LANE_SALT;
    else if (step)   lfsr <= (cur >> 1) ^ (cur[0] ? LFSR_TAPS : '0);
    else if (load)   lfsr <= seeded;
  end
endmodule

module u_gen_rand_hv_sparse_par #(
  parameter int                LENGTH_SEGMENT = 32,
  parameter int                NB_OF_SEGMENTS = 32,
  parameter int                LANES          = 4,
  parameter int                LFSR_W         = 16,
  parameter logic [LFSR_W-1:0] LFSR_TAPS      = 16'hB400
) (
  input  logic              clk,
  input  logic              arst_n_in,
  input  logic              start_new_hv,
  input  logic              seed_load,
  input  logic [LFSR_W-1:0] seed_in,
  output logic              busy,
  u_gen_rand_hv_sparse_par_if.master hv
);
  localparam int IDX_W    = $clog2(LENGTH_SEGMENT);
  localparam int NB_BEATS = NB_OF_SEGMENTS / LANES;
  localparam int BEAT_W   = (NB_BEATS > 1) ? $clog2(NB_BEATS) : 1;
  localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(NB_BEATS - 1);

  typedef enum logic {IDLE, SEND} state_t;

  state_t                                 state;
  logic                                   vld_q, last_q;
  logic [BEAT_W-1:0]                      beat_q;
  logic [LANES-1:0][IDX_W-1:0]            nxt_idx, idx_q;
  logic [LANES-1:0][LENGTH_SEGMENT-1:0]   nxt_seg, seg_q;
  logic                                   lane_load, take, accept;

  assign accept    = vld_q && hv.out_ready;
  assign lane_load = (state == IDLE) && seed_load;
  // LFSRs advance exactly when a beat is registered
  assign take      = ((state == IDLE) && start_new_hv) || ((state == SEND) && accept && !last_q);

  for (genvar g = 0; g < LANES; g++) begin : g_lane
    u_gen_rand_hv_sparse_par_lane #(
      .LFSR_W(LFSR_W), .LFSR_TAPS(LFSR_TAPS), .IDX_W(IDX_W), .LANE(g)
    ) u_lane (
      .clk(clk), .arst_n_in(arst_n_in), .load(lane_load), .seed_in(seed_in),
      .step(take), .idx(nxt_idx[g])
    );
    assign nxt_seg[g] = LENGTH_SEGMENT'(1) << nxt_idx[g];
  end

  always_ff @(posedge clk or negedge arst_n_in) begin
    if (!arst_n_in) begin
      state  <= IDLE;
      vld_q  <= 1'b0;
      last_q <= 1'b0;
      beat_q <= '0;
      idx_q  <= '0;
      seg_q  <= '0;
    end else begin
      case (state)
        IDLE: if (start_new_hv) begin
          state  <= SEND;
          vld_q  <= 1'b1;
          beat_q <= '0;
          last_q <= 1'(NB_BEATS == 1);
          idx_q  <= nxt_idx;
          seg_q  <= nxt_seg;
        end
        SEND: if (accept) begin
          if (last_q) begin
            state  <= IDLE;
            vld_q  <= 1'b0;
            last_q <= 1'b0;
            beat_q <= '0;
            idx_q  <= '0;
            seg_q  <= '0;
          end else begin
            beat_q <= beat_q + BEAT_W'(1);
            last_q <= (beat_q + BEAT_W'(1)) == LAST_BEAT;
            idx_q  <= nxt_idx;
            seg_q  <= nxt_seg;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign busy            = (state != IDLE);
  assign hv.out_valid    = vld_q;
  assign hv.out_last     = last_q;
  assign hv.out_beat_idx = beat_q;
  assign hv.out_indices  = idx_q;
  assign hv.out_segments = seg_q;
endmodule

// File: tb/tb_u_gen_rand_hv_sparse_par.sv
// Bench for the sparse HV generator: default build plus a small 8x6/2-lane
// build, each scored against a behavioural LFSR/segment model.
module tb_u_gen_rand_hv_sparse_par;
  typedef struct packed {
    logic [127:0] seg;
    logic [19:0]  idx;
    logic [2:0]   beat;
    logic         last;
  } beat_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic             arst_n;
  logic [1:0]       start, sload, rdy;
  logic [1:0][15:0] seed;
  logic             busy_a, busy_b;

  u_gen_rand_hv_sparse_par_if #(.LANES(4), .LENGTH_SEGMENT(32), .IDX_W(5), .BEAT_W(3)) aif ();
  u_gen_rand_hv_sparse_par_if #(.LANES(2), .LENGTH_SEGMENT(8),  .IDX_W(3), .BEAT_W(2)) bif ();
  assign aif.out_ready = rdy[0];
  assign bif.out_ready = rdy[1];

  u_gen_rand_hv_sparse_par dut_a (
    .clk(clk), .arst_n_in(arst_n), .start_new_hv(start[0]), .seed_load(sload[0]),
    .seed_in(seed[0]), .busy(busy_a), .hv(aif.master)
  );
  u_gen_rand_hv_sparse_par #(.LENGTH_SEGMENT(8), .NB_OF_SEGMENTS(6), .LANES(2)) dut_b (
    .clk(clk), .arst_n_in(arst_n), .start_new_hv(start[1]), .seed_load(sload[1]),
    .seed_in(seed[1]), .busy(busy_b), .hv(bif.master)
  );

  beat_t       q0[$], q1[$];
  logic [15:0] m[2][4];
  int          checks = 0, fails = 0;
  bit          rmode = 1'b0;
  logic [19:0] first_idx[2];
  logic [19:0] cap[2][8];
  logic [19:0] saved[8];
  bit          held_v[2];
  beat_t       held[2];

  function automatic int n_ls(int id);    return id ? 8 : 32; endfunction
  function automatic int n_lanes(int id); return id ? 2 : 4;  endfunction
  function automatic int n_beats(int id); return id ? 3 : 8;  endfunction
  function automatic int n_iw(int id);    return id ? 3 : 5;  endfunction
  function automatic logic vld(int id);   return id ? bif.out_valid : aif.out_valid; endfunction
  function automatic int qsize(int id);   return id ? q1.size() : q0.size(); endfunction

  task automatic chk(input string nm, input logic [159:0] act, input logic [159:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference: each lane is a Galois LFSR whose low bits pick the set bit
  function automatic logic [15:0] gstep(logic [15:0] s);
    return (s >> 1) ^ (s[0] ? 16'hB400 : 16'h0000);
  endfunction

  task automatic model_reset();
    for (int id = 0; id < 2; id++)
      for (int l = 0; l < 4; l++) m[id][l] = 16'(l + 1);
  endtask

  task automatic model_seed(input int id, input logic [15:0] s);
    for (int l = 0; l < n_lanes(id); l++) begin
      m[id][l] = s ^ 16'(l + 1);
      if (m[id][l] == 16'h0) m[id][l] = 16'h0001;
    end
  endtask

  task automatic push_hv(input int id);
    beat_t e;
    int    ix;
    for (int b = 0; b < n_beats(id); b++) begin
      e = '0;
      for (int l = 0; l < n_lanes(id); l++) begin
        ix = int'(m[id][l]) % n_ls(id);
        e.seg[l * n_ls(id) + ix] = 1'b1;
        e.idx = e.idx | (20'(ix) << (l * n_iw(id)));
        m[id][l] = gstep(m[id][l]);
      end
      e.beat = 3'(b);
      e.last = (b == n_beats(id) - 1);
      if (id == 0) q0.push_back(e); else q1.push_back(e);
    end
  endtask

  task automatic mon(input int id, input logic v, input logic r, input beat_t cur);
    beat_t e;
    if (v) begin
      if (held_v[id]) chk("stall_stable", cur, held[id]);
      chk("onehot_count", 160'($countones(cur.seg)), 160'(n_lanes(id)));
      if (r) begin
        if (qsize(id) == 0) begin
          checks++; fails++;
          $display("FAIL extra_beat dut=%0d actual=%0h expected=none", id, cur);
        end else begin
          e = (id == 0) ? q0.pop_front() : q1.pop_front();
          chk(id ? "beat_b" : "beat_a", cur, e);
          if (cur.beat == 3'd0) first_idx[id] = cur.idx;
          cap[id][cur.beat] = cur.idx;
        end
        held_v[id] = 1'b0;
      end else begin
        held_v[id] = 1'b1;
        held[id]   = cur;
      end
    end else begin
      held_v[id] = 1'b0;
      chk("idle_zero", {cur.seg, cur.idx, cur.last}, '0);
    end
  endtask

  always @(negedge clk) if (arst_n) begin
    mon(0, aif.out_valid, aif.out_ready,
        {128'(aif.out_segments), 20'(aif.out_indices), 3'(aif.out_beat_idx), aif.out_last});
    mon(1, bif.out_valid, bif.out_ready,
        {128'(bif.out_segments), 20'(bif.out_indices), 3'(bif.out_beat_idx), bif.out_last});
  end

  // Back-pressure: roughly 30% low in random mode
  initial begin
    rdy = 2'b11;
    forever begin
      @(posedge clk); #1;
      for (int i = 0; i < 2; i++) rdy[i] = rmode ? ($urandom_range(0, 99) >= 30) : 1'b1;
    end
  end

  // Called at a negedge with the DUT idle; returns at a negedge
  task automatic run_hv(input int id, input bit do_seed, input logic [15:0] s,
                        input bit mid, input bit rst3);
    int n = 0;
    if (do_seed) model_seed(id, s);
    push_hv(id);
    sload[id] = do_seed; seed[id] = s; start[id] = 1'b1;
    @(negedge clk);
    start[id] = 1'b0; sload[id] = 1'b0;
    chk("first_valid_latency", 160'(vld(id)), 160'(1));
    while (vld(id) && n < 200) begin
      if (mid && n == 2) begin
        start[id] = 1'b1; sload[id] = 1'b1; seed[id] = 16'($urandom);
      end else begin
        start[id] = 1'b0; sload[id] = 1'b0;
      end
      if (rst3 && id == 0 && aif.out_beat_idx == 3'd3) begin
        #2 arst_n = 1'b0;
        #1;
        chk("rst_mid_valid", 160'(aif.out_valid), 160'(0));
        chk("rst_mid_busy", 160'(busy_a), 160'(0));
        q0.delete(); q1.delete();
        model_reset();
        held_v[0] = 1'b0; held_v[1] = 1'b0;
        start = '0; sload = '0;
        @(negedge clk);
        arst_n = 1'b1;
        @(negedge clk);
        return;
      end
      n++;
      @(negedge clk);
    end
    start[id] = 1'b0; sload[id] = 1'b0;
    if (n >= 200) begin
      checks++; fails++;
      $display("FAIL hv_timeout dut=%0d actual=%0d expected<200", id, n);
    end
    if (!rmode) chk("hv_cycles", 160'(n), 160'(n_beats(id)));
    chk("queue_drained", 160'(qsize(id)), 160'(0));
  endtask

  initial begin
    arst_n = 1'b0; start = '0; sload = '0; seed = '0;
    held_v[0] = 1'b0; held_v[1] = 1'b0;
    model_reset();
    repeat (3) @(negedge clk);
    chk("reset_valid_a", 160'(aif.out_valid), 160'(0));
    chk("reset_busy_a", 160'(busy_a), 160'(0));
    chk("reset_outs_a", {aif.out_segments, aif.out_indices, aif.out_beat_idx, aif.out_last}, '0);
    chk("reset_valid_b", 160'(bif.out_valid), 160'(0));
    chk("reset_busy_b", 160'(busy_b), 160'(0));
    arst_n = 1'b1;
    @(negedge clk);

    run_hv(0, 1'b0, 16'h0, 1'b0, 1'b0);
    chk("beat0_post_reset", first_idx[0], {5'd4, 5'd3, 5'd2, 5'd1});
    run_hv(0, 1'b0, 16'h0, 1'b0, 1'b0);

    rmode = 1'b1;
    run_hv(0, 1'b1, 16'hACE0, 1'b0, 1'b0);
    for (int b = 0; b < 8; b++) saved[b] = cap[0][b];
    chk("seed_lane0_idx", 160'(first_idx[0][4:0]), 160'(1));
    run_hv(0, 1'b1, 16'hACE0, 1'b0, 1'b0);
    for (int b = 0; b < 8; b++) chk("reseed_repro", cap[0][b], saved[b]);

    repeat (4) run_hv(0, 1'b0, 16'h0, 1'b0, 1'b0);
    run_hv(0, 1'b1, 16'h0001, 1'b1, 1'b0);
    chk("seed_zero_lane0_idx", 160'(first_idx[0][4:0]), 160'(1));

    run_hv(0, 1'b0, 16'h0, 1'b0, 1'b1);
    rmode = 1'b0;
    @(negedge clk);
    run_hv(0, 1'b0, 16'h0, 1'b0, 1'b0);
    chk("beat0_after_mid_reset", first_idx[0], {5'd4, 5'd3, 5'd2, 5'd1});

    rmode = 1'b1;
    for (int k = 0; k < 100; k++)
      run_hv(1, $urandom_range(0, 4) == 0, 16'($urandom), 1'b0, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog");
  end
endmodule
